cg_iteration_sequencer: RTL and testbench
=========================================

// Module: cg_iteration_sequencer
// PURPOSE
//  Parametrised control core for the complex conjugate-gradient datapath. Issues start pulses to the
//  vXv, mXv, division and mul/add stages in order, and latches the rsold/rsnew scalars.
//  Loops until the residual meets a runtime tolerance, an iteration limit is hit, or a stage times out.
//  Adds over the previous generation: rsnew->rsold reuse, iteration limit, watchdog, abort and status.
// PARAMETERS
//  N_EQN     10   equations per cluster (vector length)
//  NU         8   parallel units; BURST = ceil(N_EQN/NU) read strobes per vXv pass
//  ELEM_W    64   complex element width; real part is an IEEE-754 single in [ELEM_W-1:ELEM_W/2]
//  ITER_W    16   width of iteration counter / max_iter
//  TIMEOUT 4096   max cycles any stage may run before watchdog fires
// PORTS
//  clk         in   1       clock
//  reset_n     in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse; starts a solve when idle
//  abort       in   1       level; forces return to IDLE
//  tolerance   in   32      convergence threshold (IEEE-754 single, non-negative)
//  max_iter    in   ITER_W  iteration limit; 0 = no limit
//  stage_start out  8       one-hot start pulses: [0]rsold vXv [1]mXv [2]pAp vXv [3]div alpha
//                           [4]x/r update [5]rsnew vXv [6]div beta [7]p update
//  stage_done  in   8       per-stage finish pulses, same bit map
//  vxv_result  in   ELEM_W  scalar result of the active vXv stage
//  rd_strobe   out  1       vector-read strobe for vXv stages (replaces outsider_read)
//  rsold       out  ELEM_W  latched r.r of the previous iteration (divisor of beta)
//  rsnew       out  ELEM_W  latched r.r of the current iteration
//  iter_count  out  ITER_W  completed iterations
//  busy        out  1       high from the state after IDLE until DONE
//  done        out  1       1-cycle pulse on termination
//  converged / iter_limit / timed_out  out 1 each   sticky status, cleared on next accepted start
//  state_dbg   out  4       current FSM state encoding
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; counters 0.
//  FSM: IDLE -> RSOLD -> CHK0 -> MXV -> PAP -> ALPHA -> UPD_XR -> RSNEW -> CHECK -> BETA -> UPD_P -> MXV ...
//       Any terminal condition -> DONE. DONE -> IDLE after 1 cycle.
//  Stage states: stage_start[k] pulses high exactly 1 cycle, in the first cycle of the state.
//    The FSM waits for stage_done[k]; stage_done of an inactive stage is ignored.
//    stage_done in the same cycle as the start pulse is ignored.
//  vXv stages (RSOLD, RSNEW): rd_strobe pulses BURST times, starting 1 cycle after the start pulse.
//    Pattern is high 1 / low 1 cycle. stage_done is honoured only after the last strobe.
//  Result capture: vxv_result is captured into rsold (RSOLD) or rsnew (RSNEW) in the cycle stage_done is high.
//  Convergence test (CHK0 on rsold, CHECK on rsnew), one cycle each:
//    real field sign=0 and real field <= tolerance (unsigned compare) -> converged.
//    Real sign=1 also counts as converged.
//  Order in CHECK: converged first; then iter_count+1 == max_iter (max_iter!=0) -> iter_limit; else -> BETA.
//    On any CHECK exit iter_count increments.
//  UPD_P exit: rsold <= rsnew, then MXV. RSOLD runs only in iteration 0.
//  Watchdog: cycle counter resets on every state entry.
//    Reaching TIMEOUT in a stage state -> DONE with timed_out=1; stage_start is not re-issued.
//  done pulses in the DONE state. Status flags hold until the next accepted start.
//  start while busy is ignored. abort has priority over everything.
//  abort in any state -> IDLE next cycle: no done pulse, status flags and iter_count keep their values.
//  abort and start in the same cycle in IDLE -> stays IDLE.
//  Asynchronous reset mid-solve -> immediate IDLE, all outputs 0, no done pulse.
//  iter_count saturates at 2^ITER_W-1.
// STRUCTURE
//  cg_seq_defs.vh: state encodings, stage index localparams (STG_RSOLD..STG_UPDP), BURST ceil-div macro.
//  Sub-module cg_read_burst: strobe generator (go, count=BURST -> rd_strobe, burst_done).
//    One instance, shared by RSOLD and RSNEW.
//  Top: FSM, watchdog counter, scalar registers, convergence comparator.
// TESTING
//  1 Reset check: reset_n=0 mid-MXV -> all outputs 0 and state_dbg=IDLE in the same cycle.
//  2 Initial-residual convergence: N_EQN=10, NU=8, tolerance=32'h283424DC, start.
//    RSOLD done with real=32'h20000000 -> exactly 2 rd_strobe pulses, converged=1, iter_count=0.
//  3 Three-iteration solve: bench models each stage with 5-cycle latency.
//    rsnew real = 3F800000, 3A000000, 20000000 -> done after 3rd CHECK, converged=1, iter_count=3.
//    rsold equals the prior rsnew at each BETA.
//  4 Iteration limit: max_iter=2, rsnew never <= tolerance -> iter_limit=1, iter_count=2, converged=0.
//  5 Watchdog: withhold stage_done[1] -> timed_out=1 exactly TIMEOUT cycles after the MXV start pulse.
//    stage_start[1] pulsed only once.
//  6 Abort and filtering: abort during UPD_XR -> IDLE next cycle, no done.
//    Stray stage_done[6] during MXV is ignored. start while busy is ignored.

Source files
------------

// File: rtl/cg_iteration_sequencer_pkg.sv
// Shared state encodings, stage indices and helpers
// for the conjugate-gradient iteration sequencer.
package cg_iteration_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RSOLD  = 4'd1,
    S_CHK0   = 4'd2,
    S_MXV    = 4'd3,
    S_PAP    = 4'd4,
    S_ALPHA  = 4'd5,
    S_UPD_XR = 4'd6,
    S_RSNEW  = 4'd7,
    S_CHECK  = 4'd8,
    S_BETA   = 4'd9,
    S_UPD_P  = 4'd10,
    S_DONE   = 4'd11
  } state_e;

  localparam int STG_RSOLD = 0;
  localparam int STG_MXV   = 1;
  localparam int STG_PAP   = 2;
  localparam int STG_ALPHA = 3;
  localparam int STG_UPDXR = 4;
  localparam int STG_RSNEW = 5;
  localparam int STG_BETA  = 6;
  localparam int STG_UPDP  = 7;

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic [7:0] stage_of(state_e s);
    logic [7:0] v;
    v = '0;
    case (s)
      S_RSOLD:  v[STG_RSOLD] = 1'b1;
      S_MXV:    v[STG_MXV]   = 1'b1;
      S_PAP:    v[STG_PAP]   = 1'b1;
      S_ALPHA:  v[STG_ALPHA] = 1'b1;
      S_UPD_XR: v[STG_UPDXR] = 1'b1;
      S_RSNEW:  v[STG_RSNEW] = 1'b1;
      S_BETA:   v[STG_BETA]  = 1'b1;
      S_UPD_P:  v[STG_UPDP]  = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic state_e next_stage(state_e s);
    state_e n;
    case (s)
      S_RSOLD:  n = S_CHK0;
      S_MXV:    n = S_PAP;
      S_PAP:    n = S_ALPHA;
      S_ALPHA:  n = S_UPD_XR;
      S_UPD_XR: n = S_RSNEW;
      S_RSNEW:  n = S_CHECK;
      S_BETA:   n = S_UPD_P;
      S_UPD_P:  n = S_MXV;
      default:  n = S_IDLE;
    endcase
    return n;
  endfunction

  // Negative residual real parts are treated as converged
  function automatic logic is_conv(
    logic [31:0] re,
    logic [31:0] tol
  );
    return re[31] | (re <= tol);
  endfunction

endpackage

// File: rtl/cg_read_burst.sv
// Vector-read strobe generator: count pulses,
// high one cycle / low one cycle, then done.
module cg_read_burst #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_strobe,
  output logic             o_done
);

  logic [CNT_W-1:0] r_rem;
  logic             r_active;
  logic             r_strobe;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_active <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_clr) begin
      r_rem    <= '0;
      r_active <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_go) begin
      r_rem    <= i_count - 1'b1;
      r_active <= 1'b1;
      r_strobe <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_active) begin
      if (r_strobe) begin
        r_strobe <= 1'b0;
        if (r_rem == '0) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end else begin
        r_strobe <= 1'b1;
        r_rem    <= r_rem - 1'b1;
      end
    end
  end

  assign o_strobe = r_strobe;
  assign o_done   = r_done;

endmodule

// File: rtl/cg_iteration_sequencer.sv
// CG solve sequencer: stage FSM, watchdog,
// rsold/rsnew latches and convergence test.
module cg_iteration_sequencer
  import cg_iteration_sequencer_pkg::*;
#(
  parameter int N_EQN   = 10,
  parameter int NU      = 8,
  parameter int ELEM_W  = 64,
  parameter int ITER_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       tolerance,
  input  logic [ITER_W-1:0] max_iter,
  output logic [7:0]        stage_start,
  input  logic [7:0]        stage_done,
  input  logic [ELEM_W-1:0] vxv_result,
  output logic              rd_strobe,
  output logic [ELEM_W-1:0] rsold,
  output logic [ELEM_W-1:0] rsnew,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              iter_limit,
  output logic              timed_out,
  output logic [3:0]        state_dbg
);

  localparam int BURST = ceil_div(N_EQN, NU);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_e            r_state;
  state_e            w_next;
  logic [7:0]        r_stage_start;
  logic [WD_W-1:0]   r_wd;
  logic [ELEM_W-1:0] r_rsold;
  logic [ELEM_W-1:0] r_rsnew;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_done;
  logic              r_conv;
  logic              r_lim;
  logic              r_to;

  logic [7:0]        w_stage;
  logic              w_is_stage;
  logic              w_is_vxv;
  logic              w_burst_done;
  logic              w_hit;
  logic              w_wd_exp;
  logic              w_conv_old;
  logic              w_conv_new;
  logic              w_lim;
  logic [ITER_W:0]   w_iter_inc;

  assign w_stage    = stage_of(r_state);
  assign w_is_stage = |w_stage;
  assign w_is_vxv   = (r_state == S_RSOLD) ||
                      (r_state == S_RSNEW);
  // A finish pulse in the start cycle is not ours
  assign w_hit      = w_is_stage &&
                      !(|r_stage_start) &&
                      (|(stage_done & w_stage)) &&
                      (!w_is_vxv || w_burst_done);
  assign w_wd_exp   = (r_wd == WD_W'(TIMEOUT - 1));
  assign w_conv_old = is_conv(r_rsold[ELEM_W-1 -: 32],
                              tolerance);
  assign w_conv_new = is_conv(r_rsnew[ELEM_W-1 -: 32],
                              tolerance);
  assign w_iter_inc = {1'b0, r_iter} + 1'b1;
  assign w_lim      = (|max_iter) &&
                      (w_iter_inc == {1'b0, max_iter});

  cg_read_burst #(
    .CNT_W (8)
  ) u_burst (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_go     (r_stage_start[STG_RSOLD] |
               r_stage_start[STG_RSNEW]),
    .i_clr    (abort || !w_is_vxv),
    .i_count  (8'(BURST)),
    .o_strobe (rd_strobe),
    .o_done   (w_burst_done)
  );

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:
          if (start) w_next = S_RSOLD;
        S_CHK0:
          w_next = w_conv_old ? S_DONE : S_MXV;
        S_CHECK:
          w_next = (w_conv_new || w_lim) ?
                   S_DONE : S_BETA;
        S_DONE:
          w_next = S_IDLE;
        default:
          if (!w_is_stage)  w_next = S_IDLE;
          else if (w_hit)   w_next = next_stage(r_state);
          else if (w_wd_exp) w_next = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_stage_start <= '0;
      r_wd          <= '0;
      r_rsold       <= '0;
      r_rsnew       <= '0;
      r_iter        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_conv        <= 1'b0;
      r_lim         <= 1'b0;
      r_to          <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_stage_start <= (w_next != r_state) ?
                       stage_of(w_next) : '0;
      r_wd          <= (w_next == r_state && w_is_stage) ?
                       r_wd + 1'b1 : '0;
      r_done        <= (w_next == S_DONE);
      r_busy        <= (w_next != S_IDLE) &&
                       (w_next != S_DONE);
      if (!abort) begin
        if (r_state == S_IDLE && start) begin
          r_conv <= 1'b0;
          r_lim  <= 1'b0;
          r_to   <= 1'b0;
          r_iter <= '0;
        end
        if (w_hit && r_state == S_RSOLD)
          r_rsold <= vxv_result;
        if (w_hit && r_state == S_RSNEW)
          r_rsnew <= vxv_result;
        if (w_hit && r_state == S_UPD_P)
          r_rsold <= r_rsnew;
        if (w_is_stage && !w_hit && w_wd_exp)
          r_to <= 1'b1;
        if (r_state == S_CHK0 && w_conv_old)
          r_conv <= 1'b1;
        if (r_state == S_CHECK) begin
          if (w_conv_new)  r_conv <= 1'b1;
          else if (w_lim)  r_lim  <= 1'b1;
          if (~&r_iter)    r_iter <= r_iter + 1'b1;
        end
      end
    end
  end

  assign stage_start = r_stage_start;
  assign rsold       = r_rsold;
  assign rsnew       = r_rsnew;
  assign iter_count  = r_iter;
  assign busy        = r_busy;
  assign done        = r_done;
  assign converged   = r_conv;
  assign iter_limit  = r_lim;
  assign timed_out   = r_to;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Scoreboard bench for cg_iteration_sequencer:
// 5-cycle stage models, done-time result checks.
module tb_cg_iteration_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] tolerance;
  logic [15:0] max_iter;
  logic [7:0]  stage_start;
  logic [7:0]  stage_done;
  logic [63:0] vxv_result;
  logic        rd_strobe;
  logic [63:0] rsold;
  logic [63:0] rsnew;
  logic [15:0] iter_count;
  logic        busy;
  logic        done;
  logic        converged;
  logic        iter_limit;
  logic        timed_out;
  logic [3:0]  state_dbg;

  logic [7:0]  rsp_done;
  logic [7:0]  stray;
  logic [7:0]  withhold;

  typedef struct {
    logic        conv;
    logic        lim;
    logic        to;
    logic [15:0] iter;
    int          strb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] res_q[$];
  logic [31:0] rs_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_strb = 0;
  int n_s1  = 0;
  int t_s1  = 0;
  int t_to  = 0;
  logic to_q = 1'b0;

  assign stage_done = rsp_done | stray;

  always #5 clk = ~clk;

  cg_iteration_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .tolerance   (tolerance),
    .max_iter    (max_iter),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .vxv_result  (vxv_result),
    .rd_strobe   (rd_strobe),
    .rsold       (rsold),
    .rsnew       (rsnew),
    .iter_count  (iter_count),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .iter_limit  (iter_limit),
    .timed_out   (timed_out),
    .state_dbg   (state_dbg)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  // Stage models: finish 5 cycles after each start pulse
  initial begin
    int          rsp_cnt;
    int          rsp_k;
    logic [31:0] val;
    rsp_done   = '0;
    vxv_result = '0;
    rsp_cnt    = 0;
    rsp_k      = 0;
    forever begin
      @(negedge clk);
      rsp_done = '0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0 && !withhold[rsp_k]) begin
          rsp_done[rsp_k] = 1'b1;
          if (rsp_k == 0 || rsp_k == 5) begin
            if (res_q.size() > 0) val = res_q.pop_front();
            else val = 32'h3F800000;
            vxv_result = {val, 32'h0};
            if (rsp_k == 0) rs_q.delete();
            rs_q.push_back(val);
          end
        end
      end
      for (int k = 0; k < 8; k++)
        if (stage_start[k]) begin
          rsp_k   = k;
          rsp_cnt = 5;
        end
    end
  end

  // Output monitor and scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_strobe) n_strb++;
      if (stage_start[0]) begin
        n_strb = 0;
        n_s1   = 0;
      end
      if (stage_start[1]) begin
        n_s1++;
        t_s1 = cyc;
      end
      if (timed_out && !to_q) t_to = cyc;
      to_q = timed_out;
      if (stage_start[6]) begin
        if (rs_q.size() == 0)
          chk("beta_rsold_avail", 64'd0, 64'd1);
        else
          chk("beta_rsold", rsold,
              {rs_q.pop_front(), 32'h0});
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("converged", 64'(converged), 64'(e.conv));
          chk("iter_limit", 64'(iter_limit), 64'(e.lim));
          chk("timed_out", 64'(timed_out), 64'(e.to));
          chk("iter_count", 64'(iter_count), 64'(e.iter));
          chk("strobes", 64'(n_strb), 64'(e.strb));
        end
      end
    end
  end

  task automatic wait_stage(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (stage_start[k]) seen = 1'b1;
    end
    if (!seen) chk("stage_wait", 64'd0, 64'd1);
  endtask

  task automatic run_solve(
    input logic [15:0] mi,
    input logic        c,
    input logic        l,
    input logic        t,
    input logic [15:0] it,
    input int          sb
  );
    exp_t e;
    bit   seen;
    e.conv = c;
    e.lim  = l;
    e.to   = t;
    e.iter = it;
    e.strb = sb;
    max_iter = mi;
    exp_q.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_wait", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    tolerance = 32'h283424DC;
    max_iter  = '0;
    stray     = '0;
    withhold  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl",
        {30'd0, stage_start, rd_strobe, busy, done,
         converged, iter_limit, timed_out,
         state_dbg, iter_count}, 64'd0);
    chk("reset_rsold", rsold, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Residual already small after the first r.r
    res_q.push_back(32'h20000000);
    run_solve(16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 2);

    // Three iterations, converge on third CHECK
    res_q.push_back(32'h40000000);
    res_q.push_back(32'h3F800000);
    res_q.push_back(32'h3A000000);
    res_q.push_back(32'h20000000);
    run_solve(16'd0, 1'b1, 1'b0, 1'b0, 16'd3, 8);
    chk("rsnew_final", rsnew, {32'h20000000, 32'h0});

    // Iteration limit of two
    res_q.push_back(32'h3F800000);
    res_q.push_back(32'h3F800000);
    res_q.push_back(32'h3F800000);
    run_solve(16'd2, 1'b0, 1'b1, 1'b0, 16'd2, 6);

    // Watchdog on a silent mXv stage
    withhold = 8'h02;
    res_q.push_back(32'h3F800000);
    run_solve(16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 2);
    withhold = 8'h00;
    chk("wd_cycles", 64'(t_to - t_s1), 64'd4096);
    chk("mxv_starts", 64'(n_s1), 64'd1);

    // Stray finish, start while busy, then abort
    res_q.push_back(32'h3F800000);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_stage(1);
    @(negedge clk) stray = 8'h40;
    @(negedge clk) stray = 8'h00;
    chk("stray_ignored", 64'(state_dbg), 64'd3);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_busy", 64'(state_dbg), 64'd3);
    chk("busy_mid", 64'(busy), 64'd1);
    wait_stage(4);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_idle", 64'(state_dbg), 64'd0);
    chk("abort_outs", {55'd0, busy, stage_start},
        64'd0);
    repeat (12) @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start", 64'(state_dbg), 64'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of mXv
    res_q.push_back(32'h3F800000);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_stage(1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_ctl",
        {30'd0, stage_start, rd_strobe, busy, done,
         converged, iter_limit, timed_out,
         state_dbg, iter_count}, 64'd0);
    chk("async_rsold", rsold, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
